// File: rtl/regfile_seq_pkg.sv
// Shared types and defaults for the register-file sequencer: opcodes, FSM states
// and default widths.
package regfile_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 1;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/regfile_seq_if.sv
// Command and response valid/ready channels between the control logic (master)
// and the register-file sequencer (slave).
interface regfile_seq_if
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational result/write/error decode for one sequencer command.
// SUB is executed only when REGFILE_SEQ_SUB_EN is defined; otherwise it is rejected.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              write,
  output logic              err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    result = '0;
    write  = 1'b0;
    err    = 1'b0;
    unique case (op)
      OP_LOAD: begin
        result = imm;
        write  = 1'b1;
      end
      OP_ADD: begin
        result = a + b;
        write  = 1'b1;
      end
      OP_SUB: begin
`ifdef REGFILE_SEQ_SUB_EN
        result = a - b;
        write  = 1'b1;
`else
        err    = 1'b1;
`endif
      end
      OP_READ: result = a;
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for a 2-entry register file: IDLE -> EXEC -> RESP per command.
// Build option: REGFILE_SEQ_SUB_EN enables the SUB opcode (illegal when undefined).
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  regfile_seq_if.slave      bus,
  output logic [ADDR_W-1:0] rf_read_register1,
  output logic [ADDR_W-1:0] rf_read_register2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_register,
  output logic [DATA_W-1:0] rf_write_data
);

  state_e            state, state_next;
  op_e               op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              cmd_ready_c, rsp_valid_c, exec_active;
  logic [DATA_W-1:0] alu_result;
  logic              alu_write, alu_err;
  logic              do_write;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    exec_active = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready_c = !reset;
        if (bus.cmd_valid && cmd_ready_c) state_next = EXEC;
      end
      EXEC: begin
        exec_active = !reset;
        state_next  = RESP;
      end
      RESP: begin
        rsp_valid_c = !reset;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the command holding registers are not reset; they are only consulted in EXEC, after a load.
  always_ff @(posedge clock) begin
    if (bus.cmd_valid && cmd_ready_c) begin
      op_q  <= bus.cmd_op;
      rd_q  <= bus.cmd_rd;
      rs1_q <= bus.cmd_rs1;
      rs2_q <= bus.cmd_rs2;
      imm_q <= bus.cmd_imm;
    end
  end

  regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (rf_read_data1),
    .b      (rf_read_data2),
    .imm    (imm_q),
    .result (alu_result),
    .write  (alu_write),
    .err    (alu_err)
  );

  // Response is captured at the end of EXEC and held until the consumer takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (exec_active) begin
      rsp_data_q <= alu_result;
      rsp_err_q  <= alu_err;
    end
  end

  assign do_write          = exec_active && alu_write;
  assign rf_read_register1 = exec_active ? rs1_q : '0;
  assign rf_read_register2 = exec_active ? rs2_q : '0;
  assign rf_write_enable   = do_write;
  assign rf_write_register = do_write ? rd_q : '0;
  assign rf_write_data     = do_write ? alu_result : '0;

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: directed scenarios plus randomized commands against a
// command-level register-file model; also hosts the register file itself.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  typedef struct packed {
    logic [7:0]  data;
    logic        err;
    logic [3:0]  nwr;
    logic        wreg;
    logic [7:0]  wdata;
    logic        ra1;
    logic        ra2;
    logic [3:0]  lat;
    logic [15:0] regs;
    logic        bad;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rf_read_register1, rf_read_register2;
  logic [7:0] rf_read_data1, rf_read_data2;
  logic       rf_write_enable;
  logic       rf_write_register;
  logic [7:0] rf_write_data;

  logic [7:0] rf_mem [2] = '{8'h00, 8'h00};
  int         wr_edges = 0;
  logic [7:0] model_regs [2];
  int         n_checks = 0;
  int         n_pass = 0;

  regfile_seq_if #(.DATA_W(8), .ADDR_W(1)) bus ();

  regfile_sequencer #(.DATA_W(8), .ADDR_W(1)) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .rf_read_register1 (rf_read_register1),
    .rf_read_register2 (rf_read_register2),
    .rf_read_data1     (rf_read_data1),
    .rf_read_data2     (rf_read_data2),
    .rf_write_enable   (rf_write_enable),
    .rf_write_register (rf_write_register),
    .rf_write_data     (rf_write_data)
  );

  always #5 clock = ~clock;

  assign rf_read_data1 = rf_mem[rf_read_register1];
  assign rf_read_data2 = rf_mem[rf_read_register2];

  always @(posedge clock) begin
    if (rf_write_enable) begin
      rf_mem[rf_write_register] <= rf_write_data;
      wr_edges <= wr_edges + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic string fmt(obs_t v);
    return $sformatf("data=%h err=%b nwr=%0d wreg=%0d wdata=%h ra=%0d/%0d lat=%0d regs=%h bad=%b",
                     v.data, v.err, v.nwr, v.wreg, v.wdata, v.ra1, v.ra2, v.lat, v.regs, v.bad);
  endfunction

  function automatic logic rf_outputs_nonzero();
    return rf_write_enable || rf_write_register || (rf_write_data != 8'h00) ||
           rf_read_register1 || rf_read_register2;
  endfunction

  // Command-level model: what the register file and response must look like after one command.
  task automatic model_cmd(input op_e op, input logic rd, input logic rs1, input logic rs2,
                           input logic [7:0] imm, output obs_t e);
    logic [7:0] a, b, res;
    logic       wr, err;
    a = model_regs[rs1];
    b = model_regs[rs2];
    err = 1'b0;
    case (op)
      OP_LOAD: begin res = imm;                 wr = 1'b1; end
      OP_ADD:  begin res = 8'((a + b) % 256);   wr = 1'b1; end
`ifdef REGFILE_SEQ_SUB_EN
      OP_SUB:  begin res = 8'((256 + a - b) % 256); wr = 1'b1; end
`else
      OP_SUB:  begin res = 8'h00; wr = 1'b0; err = 1'b1; end
`endif
      default: begin res = a; wr = 1'b0; end
    endcase
    if (wr) model_regs[rd] = res;
    e       = '0;
    e.data  = res;
    e.err   = err;
    e.nwr   = wr ? 4'd1 : 4'd0;
    e.wreg  = wr ? rd : 1'b0;
    e.wdata = wr ? res : 8'h00;
    e.ra1   = rs1;
    e.ra2   = rs2;
    e.lat   = 4'd2;
    e.regs  = {model_regs[1], model_regs[0]};
  endtask

  // Drives one command, optionally stalls the response, and reports what was observed.
  task automatic run_cmd(input op_e op, input logic rd, input logic rs1, input logic rs2,
                         input logic [7:0] imm, input int stall, output obs_t o);
    int n;
    o = '0;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = (stall == 0);
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    for (int lat = 1; lat <= 8; lat++) begin
      @(negedge clock);
      if (rf_write_enable) begin
        o.nwr++;
        o.wreg  = rf_write_register;
        o.wdata = rf_write_data;
      end
      if (lat == 1) begin
        o.ra1 = rf_read_register1;
        o.ra2 = rf_read_register2;
        if (bus.cmd_ready) o.bad = 1'b1;
      end else if (rf_outputs_nonzero()) begin
        o.bad = 1'b1;
      end
      if (bus.rsp_valid) begin
        o.lat = 4'(lat);
        break;
      end
    end
    o.data = bus.rsp_data;
    o.err  = bus.rsp_err;
    o.regs = {rf_mem[1], rf_mem[0]};
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      if (bus.rsp_data !== o.data || bus.rsp_err !== o.err || !bus.rsp_valid ||
          bus.cmd_ready || rf_outputs_nonzero()) o.bad = 1'b1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_LOAD;
    bus.cmd_rd = 1'b0;
    bus.cmd_rs1 = 1'b0;
    bus.cmd_rs2 = 1'b0;
    bus.cmd_imm = 8'h77;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== 11'd0 || rf_outputs_nonzero()) begin
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b data=%h rf_nonzero=%b, want all 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, rf_outputs_nonzero());
    end else n_pass++;
    bus.cmd_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || wr_edges !== 0) begin
      $display("FAIL reset_release: got cmd_ready=%b rsp_valid=%b writes=%0d, want 1/0/0",
               bus.cmd_ready, bus.rsp_valid, wr_edges);
    end else n_pass++;
  endtask

  task automatic test_load();
    obs_t o, e;
    model_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'h3C, e);
    run_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'h3C, 0, o);
    n_checks++;
    if (o !== e || o.data !== 8'h3C) $display("FAIL load_3c: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_add_wrap();
    obs_t o, e;
    model_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'hF0, e);
    run_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'hF0, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL load_r0_f0: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
    model_cmd(OP_LOAD, 1'b1, 1'b0, 1'b0, 8'h20, e);
    run_cmd(OP_LOAD, 1'b1, 1'b0, 1'b0, 8'h20, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL load_r1_20: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
    model_cmd(OP_ADD, 1'b1, 1'b0, 1'b1, 8'h00, e);
    run_cmd(OP_ADD, 1'b1, 1'b0, 1'b1, 8'h00, 0, o);
    n_checks++;
    if (o !== e || o.data !== 8'h10) $display("FAIL add_wrap: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
    model_cmd(OP_READ, 1'b0, 1'b1, 1'b0, 8'h00, e);
    run_cmd(OP_READ, 1'b0, 1'b1, 1'b0, 8'h00, 0, o);
    n_checks++;
    if (o !== e || o.data !== 8'h10 || o.nwr !== 4'd0) $display("FAIL read_r1: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_add_same();
    obs_t o, e;
    model_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'h05, e);
    run_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'h05, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL load_r0_05: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
    model_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 8'h00, e);
    run_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 8'h00, 0, o);
    n_checks++;
    if (o !== e || o.data !== 8'h0A) $display("FAIL add_self: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
    model_cmd(OP_READ, 1'b1, 1'b0, 1'b1, 8'h00, e);
    run_cmd(OP_READ, 1'b1, 1'b0, 1'b1, 8'h00, 0, o);
    n_checks++;
    if (o !== e || o.data !== 8'h0A) $display("FAIL read_r0: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_sub();
    obs_t o, e;
    model_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'h01, e);
    run_cmd(OP_LOAD, 1'b0, 1'b0, 1'b0, 8'h01, 0, o);
    model_cmd(OP_LOAD, 1'b1, 1'b0, 1'b0, 8'h02, e);
    run_cmd(OP_LOAD, 1'b1, 1'b0, 1'b0, 8'h02, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL sub_setup: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
    model_cmd(OP_SUB, 1'b0, 1'b0, 1'b1, 8'h00, e);
    run_cmd(OP_SUB, 1'b0, 1'b0, 1'b1, 8'h00, 0, o);
    n_checks++;
`ifdef REGFILE_SEQ_SUB_EN
    if (o !== e || o.data !== 8'hFF || o.err !== 1'b0)
`else
    if (o !== e || o.data !== 8'h00 || o.err !== 1'b1 || o.nwr !== 4'd0 || rf_mem[0] !== 8'h01)
`endif
      $display("FAIL sub: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_stall();
    obs_t o, e;
    logic bad;
    int   w0, n;
    model_cmd(OP_LOAD, 1'b1, 1'b0, 1'b0, 8'h5A, e);
    w0 = wr_edges;
    bus.cmd_op = OP_LOAD; bus.cmd_rd = 1'b1; bus.cmd_rs1 = 1'b0; bus.cmd_rs2 = 1'b0; bus.cmd_imm = 8'h5A;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    bus.cmd_op = OP_ADD; bus.cmd_rd = 1'b0; bus.cmd_rs1 = 1'b1; bus.cmd_rs2 = 1'b1; bus.cmd_imm = 8'h00;
    bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      if (bus.cmd_ready) bad = 1'b1;
      if (i >= 1 && (!bus.rsp_valid || bus.rsp_data !== 8'h5A || bus.rsp_err !== 1'b0)) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0 || wr_edges - w0 !== 1)
      $display("FAIL stall_hold: got unstable=%b writes=%0d, want 0/1", bad, wr_edges - w0);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    model_cmd(OP_ADD, 1'b0, 1'b1, 1'b1, 8'h00, e);
    run_cmd(OP_ADD, 1'b0, 1'b1, 1'b1, 8'h00, 0, o);
    n_checks++;
    if (o !== e || o.data !== 8'hB4) $display("FAIL stall_second_cmd: got %s, want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_reset_exec();
    int w0, n;
    w0 = wr_edges;
    bus.cmd_op = OP_LOAD; bus.cmd_rd = 1'b0; bus.cmd_rs1 = 1'b0; bus.cmd_rs2 = 1'b0; bus.cmd_imm = 8'hAA;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (rf_write_enable !== 1'b0 || bus.cmd_ready !== 1'b0)
      $display("FAIL reset_in_exec: got wen=%b cmd_ready=%b, want 0/0", rf_write_enable, bus.cmd_ready);
    else n_pass++;
    @(posedge clock);
    #1 reset = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 ||
        wr_edges !== w0 || rf_mem[0] !== model_regs[0])
      $display("FAIL reset_exec_after: got ready=%b valid=%b data=%h writes=%0d r0=%h, want 1/0/00/%0d/%h",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_data, wr_edges, rf_mem[0], w0, model_regs[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t o, e;
    op_e  op;
    logic rd, rs1, rs2;
    logic [7:0] imm;
    for (int k = 0; k < 60; k++) begin
      op  = op_e'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      rs1 = 1'($urandom_range(0, 1));
      rs2 = 1'($urandom_range(0, 1));
      imm = 8'($urandom_range(0, 255));
      model_cmd(op, rd, rs1, rs2, imm, e);
      run_cmd(op, rd, rs1, rs2, imm, int'($urandom_range(0, 3)), o);
      n_checks++;
      if (o !== e) $display("FAIL random_%0d op=%0d: got %s, want %s", k, op, fmt(o), fmt(e));
      else n_pass++;
    end
  endtask

  initial begin
    model_regs[0] = 8'h00;
    model_regs[1] = 8'h00;
    test_reset();
    test_load();
    test_add_wrap();
    test_add_same();
    test_sub();
    test_stall();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
